// File: rtl/cylon_sequencer.sv
// Cylon LED sequencer: one-hot LED pattern in three motion modes with a
// switch-selected step rate, debounced mode buttons and a pause toggle.
module cylon_sequencer #(
    parameter int NUM_LEDS        = 16,
    parameter int BASE_CYCLES     = 25_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SPEED_W         = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                btn_c,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                btn_u,
    input  logic [SPEED_W-1:0]  speed,
    output logic [NUM_LEDS-1:0] led,
    output logic [1:0]          mode,
    output logic                paused
);

    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int AW = $clog2(BASE_CYCLES) + SPEED_W + 1;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PW-1:0] P_LAST = PW'(NUM_LEDS - 1);
    localparam logic [PW-1:0] P_PREV = PW'(NUM_LEDS - 2);
    localparam logic [AW-1:0] A_BASE = AW'(BASE_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button lanes in the vectors below
    localparam int unsigned B_C = 0;
    localparam int unsigned B_L = 1;
    localparam int unsigned B_R = 2;
    localparam int unsigned B_U = 3;

    typedef enum logic [1:0] {
        MODE_CYLON  = 2'b00,
        MODE_R_TO_L = 2'b01,
        MODE_L_TO_R = 2'b10
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [3:0]          w_btn;
    logic [3:0]          r_sync1;
    logic [3:0]          r_sync2;
    logic [3:0]          r_level;
    logic [3:0]          r_press;
    logic [CW-1:0]       r_cnt [4];

    mode_t               r_mode;
    dir_t                r_dir;
    logic [PW-1:0]       r_pos;
    logic [AW-1:0]       r_acc;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_paused;

    logic                w_req_valid;
    mode_t               w_req_mode;
    logic                w_mode_change;
    logic [AW-1:0]       w_inc;
    logic [AW-1:0]       w_sum;
    logic                w_tick;
    logic [PW-1:0]       w_pos_next;
    dir_t                w_dir_next;
    logic [NUM_LEDS-1:0] w_led_next;

    assign w_btn = {btn_u, btn_r, btn_l, btn_c};

    // Two-flop synchroniser for all raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce each lane; a rising flip of the accepted level emits a press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_press <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i]   <= '0;
                    r_press[i] <= 1'b0;
                end else if (r_cnt[i] == C_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_press[i] <= r_sync2[i];
                end else begin
                    r_cnt[i]   <= r_cnt[i] + CW'(1);
                    r_press[i] <= 1'b0;
                end
            end
        end
    end

    // Mode request from press pulses, priority C > L > R
    always_comb begin
        w_req_valid = 1'b1;
        w_req_mode  = MODE_CYLON;
        if (r_press[B_C]) begin
            w_req_mode = MODE_CYLON;
        end else if (r_press[B_L]) begin
            w_req_mode = MODE_R_TO_L;
        end else if (r_press[B_R]) begin
            w_req_mode = MODE_L_TO_R;
        end else begin
            w_req_valid = 1'b0;
        end
    end

    assign w_mode_change = w_req_valid && (w_req_mode != r_mode);

    assign w_inc  = AW'(speed) + AW'(1);
    assign w_sum  = r_acc + w_inc;
    assign w_tick = !r_paused && (w_sum >= A_BASE);

    // Next position and direction for one step in the current mode
    always_comb begin
        w_pos_next = r_pos;
        w_dir_next = r_dir;
        case (r_mode)
            MODE_R_TO_L: w_pos_next = (r_pos == P_LAST) ? '0 : r_pos + PW'(1);
            MODE_L_TO_R: w_pos_next = (r_pos == '0) ? P_LAST : r_pos - PW'(1);
            default: begin
                if (r_dir == DIR_UP) begin
                    if (r_pos == P_LAST) begin
                        w_dir_next = DIR_DOWN;
                        w_pos_next = P_PREV;
                    end else begin
                        w_pos_next = r_pos + PW'(1);
                    end
                end else begin
                    if (r_pos == '0) begin
                        w_dir_next = DIR_UP;
                        w_pos_next = PW'(1);
                    end else begin
                        w_pos_next = r_pos - PW'(1);
                    end
                end
            end
        endcase
    end

    assign w_led_next = {{(NUM_LEDS-1){1'b0}}, 1'b1} << w_pos_next;

    // Mode/pause control, step timer and LED position; a mode change
    // takes precedence over a coincident step and restarts the timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_CYLON;
            r_dir    <= DIR_UP;
            r_pos    <= '0;
            r_acc    <= '0;
            r_led    <= {{(NUM_LEDS-1){1'b0}}, 1'b1};
            r_paused <= 1'b0;
        end else begin
            if (r_press[B_U]) begin
                r_paused <= !r_paused;
            end
            if (w_mode_change) begin
                r_mode <= w_req_mode;
                r_acc  <= '0;
                if (w_req_mode == MODE_R_TO_L) begin
                    r_dir <= DIR_UP;
                end else if (w_req_mode == MODE_L_TO_R) begin
                    r_dir <= DIR_DOWN;
                end
            end else if (!r_paused) begin
                if (w_tick) begin
                    r_acc <= '0;
                    r_pos <= w_pos_next;
                    r_dir <= w_dir_next;
                    r_led <= w_led_next;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign led    = r_led;
    assign mode   = r_mode;
    assign paused = r_paused;

endmodule

// File: tb/tb_cylon_sequencer.sv
// Directed bench for cylon_sequencer with NUM_LEDS=4, BASE_CYCLES=8,
// DEBOUNCE_CYCLES=4. Inputs change and outputs are sampled on the falling edge.
module tb_cylon_sequencer;

    logic       clk;
    logic       rst_n;
    logic       btn_c;
    logic       btn_l;
    logic       btn_r;
    logic       btn_u;
    logic [2:0] speed;
    logic [3:0] led;
    logic [1:0] mode;
    logic       paused;

    int checks;
    int failures;

    cylon_sequencer #(
        .NUM_LEDS        (4),
        .BASE_CYCLES     (8),
        .DEBOUNCE_CYCLES (4),
        .SPEED_W         (3)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_c  (btn_c),
        .btn_l  (btn_l),
        .btn_r  (btn_r),
        .btn_u  (btn_u),
        .speed  (speed),
        .led    (led),
        .mode   (mode),
        .paused (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge where rst_n is released (next rising edge is E1)
    task automatic do_reset(input logic [2:0] spd);
        @(negedge clk);
        rst_n = 1'b0;
        btn_c = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0;
        speed = spd;
        wait_cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL reset_led: got %b expected %b", led, 4'b0001); end
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b expected %b", mode, 2'b00); end
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL reset_paused: got %b expected %b", paused, 1'b0); end
    endtask

    task automatic test_basic_cylon();
        logic [3:0] exp_seq [8];
        logic [3:0] prev;
        exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        do_reset(3'd0);
        prev = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            wait_cyc(7);
            checks++; if (led !== prev) begin failures++; $display("FAIL basic_hold[%0d]: got %b expected %b", i, led, prev); end
            wait_cyc(1);
            checks++; if (led !== exp_seq[i]) begin failures++; $display("FAIL basic_step[%0d]: got %b expected %b", i, led, exp_seq[i]); end
            checks++; if (mode !== 2'b00) begin failures++; $display("FAIL basic_mode[%0d]: got %b expected %b", i, mode, 2'b00); end
            prev = exp_seq[i];
        end
    endtask

    task automatic test_speed();
        do_reset(3'd3);
        wait_cyc(1);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL speed3_e1: got %b expected %b", led, 4'b0001); end
        wait_cyc(1);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL speed3_e2: got %b expected %b", led, 4'b0010); end
        wait_cyc(1);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL speed3_e3: got %b expected %b", led, 4'b0010); end
        wait_cyc(1);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL speed3_e4: got %b expected %b", led, 4'b0100); end
        wait_cyc(1);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL speed3_e5: got %b expected %b", led, 4'b0100); end
        // accumulator holds 4 here; with increment 2 the next tick is two edges away
        speed = 3'd1;
        wait_cyc(1);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL speed1_e6: got %b expected %b", led, 4'b0100); end
        wait_cyc(1);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL speed1_e7: got %b expected %b", led, 4'b1000); end
        wait_cyc(3);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL speed1_e10: got %b expected %b", led, 4'b1000); end
        wait_cyc(1);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL speed1_e11: got %b expected %b", led, 4'b0100); end
        wait_cyc(3);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL speed1_e14: got %b expected %b", led, 4'b0100); end
        wait_cyc(1);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL speed1_e15: got %b expected %b", led, 4'b0010); end
    endtask

    task automatic test_mode_select();
        do_reset(3'd0);
        wait_cyc(32);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL msel_start_led: got %b expected %b", led, 4'b0100); end
        btn_l = 1'b1;
        wait_cyc(6);
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL msel_l_early: got %b expected %b", mode, 2'b00); end
        wait_cyc(1);
        checks++; if (mode !== 2'b01) begin failures++; $display("FAIL msel_l_mode: got %b expected %b", mode, 2'b01); end
        wait_cyc(3);
        btn_l = 1'b0;
        wait_cyc(4);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL msel_hold: got %b expected %b", led, 4'b0100); end
        wait_cyc(1);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL msel_step1: got %b expected %b", led, 4'b1000); end
        wait_cyc(8);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL msel_wrap: got %b expected %b", led, 4'b0001); end
        wait_cyc(8);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL msel_step3: got %b expected %b", led, 4'b0010); end
        btn_r = 1'b1;
        wait_cyc(3);
        btn_r = 1'b0;
        wait_cyc(7);
        checks++; if (mode !== 2'b01) begin failures++; $display("FAIL msel_glitch_mode: got %b expected %b", mode, 2'b01); end
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL msel_glitch_led: got %b expected %b", led, 4'b0100); end
    endtask

    task automatic test_priority();
        do_reset(3'd0);
        btn_l = 1'b1;
        wait_cyc(7);
        checks++; if (mode !== 2'b01) begin failures++; $display("FAIL prio_setup_mode: got %b expected %b", mode, 2'b01); end
        wait_cyc(3);
        btn_l = 1'b0; btn_c = 1'b1; btn_r = 1'b1;
        wait_cyc(6);
        checks++; if (mode !== 2'b01) begin failures++; $display("FAIL prio_early: got %b expected %b", mode, 2'b01); end
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL prio_led_e16: got %b expected %b", led, 4'b0010); end
        wait_cyc(1);
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL prio_c_wins: got %b expected %b", mode, 2'b00); end
        wait_cyc(3);
        btn_c = 1'b0; btn_r = 1'b0;
        wait_cyc(8);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL prio_led_e28: got %b expected %b", led, 4'b0100); end
        btn_r = 1'b1;
        wait_cyc(5);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL prio_led_e33: got %b expected %b", led, 4'b1000); end
        wait_cyc(1);
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL prio_r_early: got %b expected %b", mode, 2'b00); end
        wait_cyc(1);
        checks++; if (mode !== 2'b10) begin failures++; $display("FAIL prio_r_mode: got %b expected %b", mode, 2'b10); end
        wait_cyc(3);
        btn_r = 1'b0;
        wait_cyc(5);
        checks++; if (led !== 4'b0100) begin failures++; $display("FAIL ltor_step1: got %b expected %b", led, 4'b0100); end
        wait_cyc(8);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL ltor_step2: got %b expected %b", led, 4'b0010); end
        wait_cyc(8);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL ltor_step3: got %b expected %b", led, 4'b0001); end
        wait_cyc(8);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL ltor_wrap: got %b expected %b", led, 4'b1000); end
    endtask

    task automatic test_pause();
        do_reset(3'd0);
        btn_u = 1'b1;
        wait_cyc(6);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL pause_early: got %b expected %b", paused, 1'b0); end
        wait_cyc(1);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_set: got %b expected %b", paused, 1'b1); end
        wait_cyc(3);
        btn_u = 1'b0; btn_r = 1'b1;
        wait_cyc(7);
        checks++; if (mode !== 2'b10) begin failures++; $display("FAIL pause_mode_r: got %b expected %b", mode, 2'b10); end
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL pause_led_e17: got %b expected %b", led, 4'b0001); end
        wait_cyc(3);
        btn_r = 1'b0;
        wait_cyc(6);
        btn_c = 1'b1;
        wait_cyc(7);
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL pause_mode_c: got %b expected %b", mode, 2'b00); end
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL pause_led_e33: got %b expected %b", led, 4'b0001); end
        wait_cyc(3);
        btn_c = 1'b0;
        wait_cyc(20);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL pause_led_e56: got %b expected %b", led, 4'b0001); end
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL pause_held: got %b expected %b", paused, 1'b1); end
        btn_u = 1'b1;
        wait_cyc(6);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL unpause_early: got %b expected %b", paused, 1'b1); end
        wait_cyc(1);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL unpause: got %b expected %b", paused, 1'b0); end
        wait_cyc(3);
        btn_u = 1'b0;
        wait_cyc(4);
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL unpause_hold: got %b expected %b", led, 4'b0001); end
        wait_cyc(1);
        checks++; if (led !== 4'b0010) begin failures++; $display("FAIL unpause_step: got %b expected %b", led, 4'b0010); end
    endtask

    task automatic test_async_reset();
        do_reset(3'd0);
        btn_r = 1'b1;
        wait_cyc(10);
        btn_r = 1'b0;
        wait_cyc(5);
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL areset_setup_led: got %b expected %b", led, 4'b1000); end
        btn_u = 1'b1;
        wait_cyc(10);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL areset_setup_paused: got %b expected %b", paused, 1'b1); end
        checks++; if (mode !== 2'b10) begin failures++; $display("FAIL areset_setup_mode: got %b expected %b", mode, 2'b10); end
        checks++; if (led !== 4'b1000) begin failures++; $display("FAIL areset_setup_led2: got %b expected %b", led, 4'b1000); end
        // assert reset between clock edges; outputs must respond without an edge
        #2 rst_n = 1'b0;
        #1;
        checks++; if (led !== 4'b0001) begin failures++; $display("FAIL areset_led: got %b expected %b", led, 4'b0001); end
        checks++; if (mode !== 2'b00) begin failures++; $display("FAIL areset_mode: got %b expected %b", mode, 2'b00); end
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL areset_paused: got %b expected %b", paused, 1'b0); end
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(6);
        checks++; if (paused !== 1'b0) begin failures++; $display("FAIL areset_rebounce_early: got %b expected %b", paused, 1'b0); end
        wait_cyc(1);
        checks++; if (paused !== 1'b1) begin failures++; $display("FAIL areset_rebounce: got %b expected %b", paused, 1'b1); end
        btn_u = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_c    = 1'b0;
        btn_l    = 1'b0;
        btn_r    = 1'b0;
        btn_u    = 1'b0;
        speed    = 3'd0;
        test_reset();
        test_basic_cylon();
        test_speed();
        test_mode_select();
        test_priority();
        test_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cylon_sequencer.md
Name: cylon_sequencer

Overview:
Parametrised successor to the fixed 16-LED cylon top level. It generates a one-hot LED pattern for NUM_LEDS outputs in three motion modes, with a switch-selected speed. Each button is synchronised, debounced and converted to a single-cycle press pulse. A fourth button toggles pause. It sits directly between the board buttons/switches and the LED pins.

Parameters:
NUM_LEDS, 16, number of LED outputs; legal range is 2 or more.
BASE_CYCLES, 25_000_000, clock cycles per step at speed=0; legal range is 2 or more.
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples required to accept a button level change.
SPEED_W, 3, width of the speed input.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
btn_c  in  1  raw button: select CYLON mode
btn_l  in  1  raw button: select R_TO_L mode (lit LED moves toward MSB)
btn_r  in  1  raw button: select L_TO_R mode (lit LED moves toward LSB)
btn_u  in  1  raw button: toggle pause
speed  in  SPEED_W  speed multiplier; step period = ceil(BASE_CYCLES/(speed+1))
led  out  NUM_LEDS  one-hot LED drive, registered
mode  out  2  current mode: 00 CYLON, 01 R_TO_L, 10 L_TO_R; 11 is never produced
paused  out  1  1 while motion is frozen

Behaviour:
- Reset (rst_n=0, asynchronous):
  - led=1 (bit 0 lit), mode=00, paused=0.
  - Internal: pos=0, dir=up, step counter=0, all debouncers at level 0 with counters at 0.
  - Normal operation resumes on the first clk edge after rst_n goes high.
- Button conditioning (identical instance per button):
  - 2-flop synchroniser feeding a debounce counter.
  - The counter resets whenever the synchronised level equals the accepted level.
  - The accepted level flips after DEBOUNCE_CYCLES consecutive cycles in which the synchronised level differs from it.
  - A 0->1 flip of the accepted level produces a 1-cycle press pulse. Release produces nothing.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Mode select:
  - On a press pulse, mode updates the next cycle.
  - Simultaneous pulses: priority C > L > R.
  - Pressing the current mode's button has no effect.
  - On a mode change: pos is kept; the step counter clears to 0.
  - Direction on mode change: R_TO_L forces dir=up, L_TO_R forces dir=down, CYLON keeps the current dir.
- Pause:
  - A btn_u press pulse toggles paused.
  - A pause pulse in the same cycle as a mode pulse: both take effect.
  - While paused=1: the step counter and led freeze; mode changes are still accepted and still clear the counter.
- Step timer:
  - Each unpaused cycle: acc <= acc + (speed+1).
  - When acc + (speed+1) >= BASE_CYCLES: acc <= 0 and a step tick fires.
  - acc width = clog2(BASE_CYCLES) + SPEED_W + 1, which guarantees no overflow.
  - A speed change takes effect on the next cycle; acc is not cleared.
- Step (on tick), with led <= one-hot(pos_next) registered the same edge (led lags tick by 1 cycle):
  - CYLON, dir=up: pos+1. At pos=NUM_LEDS-1: dir<=down, pos<=NUM_LEDS-2.
  - CYLON, dir=down: pos-1. At pos=0: dir<=up, pos<=1.
  - R_TO_L: pos+1, wrapping from NUM_LEDS-1 to 0.
  - L_TO_R: pos-1, wrapping from 0 to NUM_LEDS-1.
- Invariants:
  - led is always exactly one-hot.
  - pos never leaves the range 0..NUM_LEDS-1.

Test Plan:
Params used by all scenarios: NUM_LEDS=4, BASE_CYCLES=8, DEBOUNCE_CYCLES=4.
1. Reset release, speed=0, no buttons -> led steps every 8 cycles: 0001,0010,0100,1000,0100,0010,0001,0010; mode=00 throughout.
2. speed=3 -> step every 2 cycles. Switch to speed=1 mid-run -> step every 4 cycles from the next tick onward; sequence stays continuous.
3. btn_l high for 10 cycles while led=0100, dir=down -> mode=01 exactly 2+4+1 cycles after btn_l rises; then led sequence 1000,0001,0010 at 8-cycle spacing. A 3-cycle btn_r glitch -> mode unchanged.
4. btn_c and btn_r rise on the same cycle while mode=01 -> mode=00. Then btn_r alone -> mode=10, led cycles 0100,0010,0001,1000.
5. btn_u press -> paused=1 and led frozen for 50 cycles; btn_c during pause -> mode=00, led still frozen. Second btn_u press -> first step exactly 8 cycles after paused falls.
6. rst_n low mid-step with led=1000, mode=10, paused=1 -> led=0001, mode=00, paused=0 immediately without a clk edge. A button held through reset release must be re-debounced before it takes effect.
